// File: rtl/egress_vlan_tagger.sv
// rtl/egress_vlan_tagger.sv - per-port egress VLAN filter/tagger, 64-bit crossbar in, 32-bit port out
// Optional build macro EGRESS_NATIVE_UNTAGGED_EN: trunk frames on the native VLAN leave untagged.
module egress_vlan_tagger #(
    parameter logic [15:0] TPID             = 16'h8100,
    parameter int          DROP_COUNT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        areset_n,
    input  logic [63:0]                 s_tdata,
    input  logic [7:0]                  s_tkeep,
    input  logic                        s_tvalid,
    output logic                        s_tready,
    input  logic                        s_tlast,
    input  logic [11:0]                 s_tuser,
    output logic [31:0]                 m_tdata,
    output logic [3:0]                  m_tkeep,
    output logic                        m_tvalid,
    input  logic                        m_tready,
    output logic                        m_tlast,
    output logic [0:0]                  m_tuser,
    input  logic [11:0]                 port_vlan,
    input  logic                        port_trunk,
    output logic [DROP_COUNT_WIDTH-1:0] drop_count
);

`ifdef EGRESS_NATIVE_UNTAGGED_EN
    localparam bit NATIVE_UNTAG = 1'b1;
`else
    localparam bit NATIVE_UNTAG = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, SEND_HI, SEND_LO, SEND_TAG, DROP} state_t;

    state_t      state, state_nxt;
    logic [63:0] hold_data;
    logic [7:0]  hold_keep;
    logic        hold_last;
    logic [1:0]  hold_idx;
    logic        hold_tag;
    logic [11:0] hold_vid;
    logic        ready_en;

    logic        rdy, take_first, load_beat, first, out_upd, valid_nxt, drop_inc;
    logic        tag_here, lo_empty, final_word, f_drop, f_tag;
    logic [63:0] ld_data;
    logic [7:0]  ld_keep;
    logic        ld_last, ld_tag;
    logic [1:0]  ld_idx;
    logic [11:0] ld_vid;
    logic [31:0] nxt_data;
    logic [3:0]  nxt_keep;
    logic        nxt_last;

    assign tag_here   = hold_tag && (hold_idx == 2'd1);
    assign lo_empty   = (hold_keep[3:0] == 4'h0);
    // The word currently presented is the last one this held beat produces.
    assign final_word = (state == SEND_LO)
                     || (state == SEND_HI && !tag_here && lo_empty)
                     || (state == SEND_TAG && lo_empty);
    assign f_drop     = s_tlast || (!port_trunk && (s_tuser != port_vlan));
    assign f_tag      = port_trunk && !(NATIVE_UNTAG && (s_tuser == port_vlan));

    assign s_tready   = rdy;
    assign m_tuser    = 1'b0;

    always_comb begin
        state_nxt  = state;
        rdy        = 1'b0;
        take_first = 1'b0;
        load_beat  = 1'b0;
        first      = 1'b0;
        out_upd    = 1'b0;
        valid_nxt  = m_tvalid;
        drop_inc   = 1'b0;
        case (state)
            IDLE: begin
                rdy        = ready_en;
                take_first = s_tvalid && ready_en;
            end
            DROP: begin
                rdy = ready_en;
                if (s_tvalid && ready_en && s_tlast)
                    state_nxt = IDLE;
            end
            default: begin
                if (final_word) begin
                    // Also ready while starved mid-frame, when nothing is on the output.
                    rdy = m_tready || !m_tvalid;
                    if (rdy) begin
                        if (hold_last) begin
                            if (s_tvalid) begin
                                take_first = 1'b1;
                            end else begin
                                state_nxt = IDLE;
                                valid_nxt = 1'b0;
                            end
                        end else if (s_tvalid) begin
                            load_beat = 1'b1;
                            state_nxt = SEND_HI;
                            out_upd   = 1'b1;
                            valid_nxt = 1'b1;
                        end else begin
                            valid_nxt = 1'b0;
                        end
                    end
                end else if (m_tready) begin
                    state_nxt = (state == SEND_HI && tag_here) ? SEND_TAG : SEND_LO;
                    out_upd   = 1'b1;
                end
            end
        endcase
        if (take_first) begin
            load_beat = 1'b1;
            first     = 1'b1;
            if (f_drop) begin
                drop_inc  = 1'b1;
                valid_nxt = 1'b0;
                state_nxt = s_tlast ? IDLE : DROP;
            end else begin
                state_nxt = SEND_HI;
                out_upd   = 1'b1;
                valid_nxt = 1'b1;
            end
        end
    end

    always_comb begin
        ld_data = load_beat ? s_tdata : hold_data;
        ld_keep = load_beat ? s_tkeep : hold_keep;
        ld_last = load_beat ? s_tlast : hold_last;
        ld_tag  = first ? f_tag : hold_tag;
        ld_vid  = first ? s_tuser : hold_vid;
        if (first)
            ld_idx = 2'd0;
        else if (load_beat)
            ld_idx = (hold_idx == 2'd2) ? 2'd2 : 2'(hold_idx + 2'd1);
        else
            ld_idx = hold_idx;

        nxt_data = ld_data[63:32];
        nxt_keep = ld_keep[7:4];
        nxt_last = ld_last && (ld_keep[3:0] == 4'h0) && !(ld_tag && ld_idx == 2'd1);
        case (state_nxt)
            SEND_TAG: begin
                nxt_data = {TPID, 4'h0, ld_vid};
                nxt_keep = 4'hF;
                nxt_last = ld_last && (ld_keep[3:0] == 4'h0);
            end
            SEND_LO: begin
                nxt_data = ld_data[31:0];
                nxt_keep = ld_keep[3:0];
                nxt_last = ld_last;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state      <= IDLE;
            hold_data  <= '0;
            hold_keep  <= '0;
            hold_last  <= 1'b0;
            hold_idx   <= 2'd0;
            hold_tag   <= 1'b0;
            hold_vid   <= '0;
            ready_en   <= 1'b0;
            m_tdata    <= '0;
            m_tkeep    <= '0;
            m_tlast    <= 1'b0;
            m_tvalid   <= 1'b0;
            drop_count <= '0;
        end else begin
            state    <= state_nxt;
            ready_en <= 1'b1;
            m_tvalid <= valid_nxt;
            if (load_beat) begin
                hold_data <= ld_data;
                hold_keep <= ld_keep;
                hold_last <= ld_last;
                hold_idx  <= ld_idx;
                hold_tag  <= ld_tag;
                hold_vid  <= ld_vid;
            end
            if (out_upd) begin
                m_tdata <= nxt_data;
                m_tkeep <= nxt_keep;
                m_tlast <= nxt_last;
            end
            if (drop_inc && (drop_count != {DROP_COUNT_WIDTH{1'b1}}))
                drop_count <= drop_count + DROP_COUNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_egress_vlan_tagger.sv
// tb/tb_egress_vlan_tagger.sv - scoreboard bench for egress_vlan_tagger
module tb_egress_vlan_tagger;
    logic        clk = 1'b0;
    logic        areset_n = 1'b0;
    logic [63:0] s_tdata = '0;
    logic [7:0]  s_tkeep = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic        s_tlast = 1'b0;
    logic [11:0] s_tuser = '0;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        m_tlast;
    logic [0:0]  m_tuser;
    logic [11:0] port_vlan = 12'd69;
    logic        port_trunk = 1'b0;
    logic [3:0]  drop_count;

    egress_vlan_tagger #(.TPID(16'h8100), .DROP_COUNT_WIDTH(4)) dut (
        .clk(clk), .areset_n(areset_n),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_tlast(s_tlast), .s_tuser(s_tuser),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tlast(m_tlast), .m_tuser(m_tuser),
        .port_vlan(port_vlan), .port_trunk(port_trunk), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    logic [36:0] exp_q[$];
    logic [36:0] obs_q[$];
    int          obs_c[$];
    int n_cmp = 0, n_bad = 0;
    int ncyc = 0, rise_cyc = 0, first_acc_cyc = 0;
    int stab_err = 0, valid_cyc = 0, user_err = 0, in_stalls = 0, exp_drops = 0;
    bit toggle_mode = 1'b0, prev_stall = 1'b0, prev_valid = 1'b0;
    logic [36:0] prev_out = '0;

    // Output monitor: m_tready is chosen here, and a word is recorded when it will transfer at the next edge.
    always @(negedge clk) begin
        ncyc++;
        if (prev_stall && ({m_tvalid, m_tdata, m_tkeep, m_tlast} !== {1'b1, prev_out}))
            stab_err++;
        m_tready = toggle_mode ? !m_tready : 1'b1;
        if (m_tvalid && !prev_valid) rise_cyc = ncyc;
        if (m_tvalid) valid_cyc++;
        if (m_tvalid && (m_tuser !== 1'b0)) user_err++;
        if (m_tvalid && m_tready) begin
            obs_q.push_back({m_tdata, m_tkeep, m_tlast});
            obs_c.push_back(ncyc);
        end
        prev_stall = m_tvalid && !m_tready;
        prev_out   = {m_tdata, m_tkeep, m_tlast};
        prev_valid = m_tvalid;
    end

    function automatic logic [7:0] byte_at(input int seed, input int i);
        return 8'((seed * 37 + i * 5) & 255);
    endfunction

    task automatic push_exp(input int len, input int seed, input int vid, input bit tag);
        logic [7:0]  q[$];
        logic [11:0] v;
        logic [31:0] d;
        logic [3:0]  k;
        v = 12'(vid);
        for (int i = 0; i < len; i++) begin
            if (tag && i == 12) begin
                q.push_back(8'h81); q.push_back(8'h00);
                q.push_back({4'h0, v[11:8]}); q.push_back(v[7:0]);
            end
            q.push_back(byte_at(seed, i));
        end
        for (int w = 0; w * 4 < q.size(); w++) begin
            d = '0; k = '0;
            for (int j = 0; j < 4; j++)
                if (w * 4 + j < q.size()) begin
                    d[31 - 8 * j -: 8] = q[w * 4 + j];
                    k[3 - j] = 1'b1;
                end
            exp_q.push_back({d, k, (w * 4 + 4 >= q.size())});
        end
    endtask

    task automatic send_frame(input int len, input int vid, input int seed, input int stop_after);
        int nb, lim, waits;
        bit acc;
        nb  = (len + 7) / 8;
        lim = (stop_after > 0) ? stop_after : nb;
        for (int b = 0; b < lim; b++) begin
            @(negedge clk);
            s_tvalid = 1'b1; s_tuser = 12'(vid); s_tlast = (b == nb - 1);
            s_tdata = '0; s_tkeep = '0;
            for (int j = 0; j < 8; j++)
                if (b * 8 + j < len) begin
                    s_tdata[63 - 8 * j -: 8] = byte_at(seed, b * 8 + j);
                    s_tkeep[7 - j] = 1'b1;
                end
            waits = 0;
            forever begin
                #4;
                acc = s_tready;
                if (b == 0) first_acc_cyc = ncyc;
                @(posedge clk);
                if (acc) break;
                in_stalls++; waits++;
                if (waits > 2000) begin
                    n_cmp++; n_bad++;
                    $display("FAIL input_accept_timeout beat %0d got no s_tready exp accept", b);
                    break;
                end
                @(negedge clk);
            end
        end
        @(negedge clk);
        s_tvalid = 1'b0; s_tlast = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (obs_q.size() < exp_q.size() && t < 3000) begin
            @(negedge clk); t++;
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        areset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL rst_m_tvalid got %b exp 0", m_tvalid); end
        n_cmp++; if ({m_tdata, m_tkeep, m_tlast} !== 37'd0) begin n_bad++; $display("FAIL rst_m_fields got %h exp 0", {m_tdata, m_tkeep, m_tlast}); end
        n_cmp++; if (s_tready !== 1'b0) begin n_bad++; $display("FAIL rst_s_tready got %b exp 0", s_tready); end
        n_cmp++; if (drop_count !== 4'd0) begin n_bad++; $display("FAIL rst_drop_count got %0d exp 0", drop_count); end
        areset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (s_tready !== 1'b1) begin n_bad++; $display("FAIL idle_s_tready got %b exp 1", s_tready); end
    endtask

    task automatic test_access_forward();
        logic [36:0] e, o;
        port_trunk = 1'b0; port_vlan = 12'd69;
        push_exp(64, 1, 69, 1'b0);
        send_frame(64, 69, 1, 0);
        wait_drain();
        n_cmp++; if (rise_cyc != first_acc_cyc + 1) begin n_bad++; $display("FAIL fwd_latency got %0d exp %0d", rise_cyc - first_acc_cyc, 1); end
        n_cmp++; if (obs_q.size() != 16) begin n_bad++; $display("FAIL fwd_word_count got %0d exp 16", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_bad++; $display("FAIL fwd_word got %h exp %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        n_cmp++; if (drop_count !== 4'(exp_drops)) begin n_bad++; $display("FAIL fwd_drop_count got %0d exp %0d", drop_count, exp_drops); end
        n_cmp++; if (user_err != 0) begin n_bad++; $display("FAIL m_tuser_zero got %0d nonzero beats exp 0", user_err); end
    endtask

    task automatic test_access_drop();
        logic [36:0] e, o;
        int v0, s0;
        port_trunk = 1'b0; port_vlan = 12'd69;
        v0 = valid_cyc; s0 = in_stalls;
        send_frame(64, 70, 9, 0);
        if (exp_drops < 15) exp_drops++;
        n_cmp++; if (valid_cyc != v0) begin n_bad++; $display("FAIL drop_no_valid got %0d valid cycles exp 0", valid_cyc - v0); end
        n_cmp++; if (in_stalls != s0) begin n_bad++; $display("FAIL drop_ready_high got %0d stalls exp 0", in_stalls - s0); end
        n_cmp++; if (drop_count !== 4'(exp_drops)) begin n_bad++; $display("FAIL drop_count got %0d exp %0d", drop_count, exp_drops); end
        push_exp(64, 2, 69, 1'b0);
        send_frame(64, 69, 2, 0);
        wait_drain();
        n_cmp++; if (obs_q.size() != 16) begin n_bad++; $display("FAIL after_drop_count got %0d exp 16", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_bad++; $display("FAIL after_drop_word got %h exp %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_trunk_tag();
        logic [36:0] e, o;
        port_trunk = 1'b1; port_vlan = 12'd69;
        push_exp(60, 3, 12'h123, 1'b1);
        send_frame(60, 12'h123, 3, 0);
        wait_drain();
        n_cmp++; if (obs_q.size() != 16) begin n_bad++; $display("FAIL tag_word_count got %0d exp 16", obs_q.size()); end
        if (obs_q.size() > 3) begin
            n_cmp++; if (obs_q[3] !== {32'h81000123, 4'hF, 1'b0}) begin n_bad++; $display("FAIL tag_word3 got %h exp %h", obs_q[3], {32'h81000123, 4'hF, 1'b0}); end
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_bad++; $display("FAIL tag_word got %h exp %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_native_vlan();
        logic [36:0] e, o;
        bit nat_tag;
        int n_exp;
        nat_tag = 1'b1;
`ifdef EGRESS_NATIVE_UNTAGGED_EN
        nat_tag = 1'b0;
`endif
        port_trunk = 1'b1; port_vlan = 12'd69;
        push_exp(60, 4, 69, nat_tag);
        n_exp = exp_q.size();
        send_frame(60, 69, 4, 0);
        wait_drain();
        n_cmp++; if (obs_q.size() != n_exp) begin n_bad++; $display("FAIL native_word_count got %0d exp %0d", obs_q.size(), n_exp); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_bad++; $display("FAIL native_word got %h exp %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_backpressure();
        logic [36:0] e, o;
        stab_err = 0;
        toggle_mode = 1'b1;
        port_trunk = 1'b0; port_vlan = 12'd69;
        push_exp(63, 5, 69, 1'b0);
        send_frame(63, 69, 5, 0);
        wait_drain();
        n_cmp++; if (obs_q.size() != 16) begin n_bad++; $display("FAIL bp_word_count got %0d exp 16", obs_q.size()); end
        if (obs_q.size() == 16) begin
            n_cmp++; if (obs_q[15][4:0] !== {4'hE, 1'b1}) begin n_bad++; $display("FAIL bp_last_keep got %h exp %h", obs_q[15][4:0], {4'hE, 1'b1}); end
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_bad++; $display("FAIL bp_word got %h exp %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        port_trunk = 1'b1;
        push_exp(13, 6, 5, 1'b1);
        send_frame(13, 5, 6, 0);
        wait_drain();
        n_cmp++; if (obs_q.size() != 5) begin n_bad++; $display("FAIL bp_short_tag_count got %0d exp 5", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_bad++; $display("FAIL bp_short_tag_word got %h exp %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        toggle_mode = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (stab_err != 0) begin n_bad++; $display("FAIL bp_stable got %0d changes exp 0", stab_err); end
    endtask

    task automatic test_back_to_back();
        logic [36:0] e, o;
        port_trunk = 1'b0; port_vlan = 12'd69;
        obs_c.delete();
        push_exp(16, 7, 69, 1'b0);
        push_exp(16, 8, 69, 1'b0);
        send_frame(16, 69, 7, 0);
        send_frame(16, 69, 8, 0);
        wait_drain();
        n_cmp++; if (obs_q.size() != 8) begin n_bad++; $display("FAIL b2b_word_count got %0d exp 8", obs_q.size()); end
        if (obs_c.size() == 8) begin
            n_cmp++; if (obs_c[7] - obs_c[0] != 7) begin n_bad++; $display("FAIL b2b_span got %0d cycles exp 7", obs_c[7] - obs_c[0]); end
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_bad++; $display("FAIL b2b_word got %h exp %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_drop_saturation();
        port_trunk = 1'b0; port_vlan = 12'd69;
        for (int i = 0; i < 16; i++) begin
            send_frame(8, (i % 2 == 0) ? 69 : 70, 10 + i, 0);
            if (exp_drops < 15) exp_drops++;
        end
        n_cmp++; if (drop_count !== 4'(exp_drops)) begin n_bad++; $display("FAIL sat_count got %0d exp %0d", drop_count, exp_drops); end
        send_frame(24, 70, 30, 0);
        if (exp_drops < 15) exp_drops++;
        repeat (4) @(negedge clk);
        n_cmp++; if (drop_count !== 4'(exp_drops)) begin n_bad++; $display("FAIL sat_hold got %0d exp %0d", drop_count, exp_drops); end
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL runt_no_output got %0d words exp 0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_reset_midframe();
        logic [36:0] e, o;
        port_trunk = 1'b0; port_vlan = 12'd69;
        send_frame(64, 69, 40, 3);
        #2 areset_n = 1'b0;
        #1;
        n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid got %b exp 0", m_tvalid); end
        n_cmp++; if (s_tready !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ready got %b exp 0", s_tready); end
        n_cmp++; if (drop_count !== 4'd0) begin n_bad++; $display("FAIL mid_rst_count got %0d exp 0", drop_count); end
        @(negedge clk);
        areset_n = 1'b1;
        exp_drops = 0;
        obs_q.delete(); exp_q.delete();
        repeat (2) @(negedge clk);
        push_exp(32, 41, 69, 1'b0);
        send_frame(32, 69, 41, 0);
        wait_drain();
        n_cmp++; if (obs_q.size() != 8) begin n_bad++; $display("FAIL post_rst_count got %0d exp 8", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_bad++; $display("FAIL post_rst_word got %h exp %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_access_forward();
        test_access_drop();
        test_trunk_tag();
        test_native_vlan();
        test_backpressure();
        test_back_to_back();
        test_drop_saturation();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
